// File: rtl/wb_fetch_unit_if.sv
// Bus bundle for wb_fetch_unit: load/ALU write-back, instruction-memory port and decode handshake.
interface wb_fetch_unit_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MEM_W   = 16,
    parameter int unsigned INSTR_W = 16
);
    logic               load_start_i;
    logic [1:0]         load_size_i;
    logic               load_signed_i;
    logic [MEM_W-1:0]   data_read_i;
    logic               data_valid_i;
    logic [XLEN-1:0]    data_calc_i;
    logic               calc_valid_i;
    logic [XLEN-1:0]    write_back_o;
    logic               wb_valid_o;
    logic               wb_busy_o;
    logic               stall_fetch_i;
    logic               branch_i;
    logic [XLEN-1:0]    branch_pc_i;
    logic [XLEN-1:0]    instr_mem_addr_o;
    logic               instr_mem_re_o;
    logic [INSTR_W-1:0] instr_rdata_i;
    logic               instr_rvalid_i;
    logic               fetch_valid_o;
    logic               fetch_ready_i;
    logic [INSTR_W-1:0] fetch_instr_o;
    logic [XLEN-1:0]    fetch_pc_o;
    logic [XLEN-1:0]    next_pc_o;

    modport slave (
        input  load_start_i, load_size_i, load_signed_i, data_read_i, data_valid_i,
        input  data_calc_i, calc_valid_i, stall_fetch_i, branch_i, branch_pc_i,
        input  instr_rdata_i, instr_rvalid_i, fetch_ready_i,
        output write_back_o, wb_valid_o, wb_busy_o, instr_mem_addr_o, instr_mem_re_o,
        output fetch_valid_o, fetch_instr_o, fetch_pc_o, next_pc_o
    );

    modport master (
        output load_start_i, load_size_i, load_signed_i, data_read_i, data_valid_i,
        output data_calc_i, calc_valid_i, stall_fetch_i, branch_i, branch_pc_i,
        output instr_rdata_i, instr_rvalid_i, fetch_ready_i,
        input  write_back_o, wb_valid_o, wb_busy_o, instr_mem_addr_o, instr_mem_re_o,
        input  fetch_valid_o, fetch_instr_o, fetch_pc_o, next_pc_o
    );
endinterface

// File: rtl/wb_fetch_unit.sv
// Combined write-back (multi-beat load assembly, load/ALU mux) and instruction fetch
// (PC, latency-1 request issue, fetch queue toward decode with branch flush).
module wb_fetch_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    MEM_W    = 16,
    parameter int unsigned    INSTR_W  = 16,
    parameter int unsigned    FQ_DEPTH = 2,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_fetch_unit_if.slave bus
);
    localparam int unsigned MAX_NB = XLEN / MEM_W;
    localparam int unsigned CNT_W  = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;
    localparam int unsigned PTR_W  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned QCNT_W = $clog2(FQ_DEPTH + 1);
    localparam int unsigned STEP_B = INSTR_W / 8;

    typedef enum logic {S_IDLE, S_COLLECT} state_e;

    function automatic int unsigned load_bits(input logic [1:0] size);
        int unsigned b;
        case (size)
            2'd0:    b = 8;
            2'd1:    b = 16;
            default: b = 32;
        endcase
        return (b > XLEN) ? XLEN : b;
    endfunction

    function automatic int unsigned load_beats(input logic [1:0] size);
        int unsigned nb;
        nb = load_bits(size) / MEM_W;
        return (nb == 0) ? 1 : nb;
    endfunction

    // Keep the low load-width bits, then zero or sign fill above them.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0] size, input logic sgn);
        int unsigned     w;
        logic [XLEN-1:0] mask;
        w    = load_bits(size);
        mask = ~({XLEN{1'b1}} << w);
        if (sgn && ((raw & (XLEN'(1) << (w - 1))) != '0)) return raw | ~mask;
        return raw & mask;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   asm_q, asm_d;
    logic              wb_valid_c;
    logic [XLEN-1:0]   wb_data_c;
    logic [1:0]        cur_size;
    logic              cur_sgn;
    logic [CNT_W-1:0]  beat_idx;
    logic [XLEN-1:0]   merged;
    logic              last_beat;

    // Load assembly and write-back mux; the final beat bypasses the assembly register.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        wb_valid_c = 1'b0;
        wb_data_c  = '0;
        cur_size   = size_q;
        cur_sgn    = sgn_q;
        beat_idx   = cnt_q;
        merged     = asm_q;
        if (state_q == S_IDLE) begin
            cur_size = bus.load_size_i;
            cur_sgn  = bus.load_signed_i;
            beat_idx = '0;
            merged   = '0;
        end
        merged    = merged | (XLEN'(bus.data_read_i) << (32'(beat_idx) * MEM_W));
        last_beat = (32'(beat_idx) + 32'd1) >= load_beats(cur_size);

        case (state_q)
            S_IDLE: begin
                if (bus.calc_valid_i) begin
                    wb_valid_c = 1'b1;
                    wb_data_c  = bus.data_calc_i;
                end
                if (bus.load_start_i) begin
                    size_d  = cur_size;
                    sgn_d   = cur_sgn;
                    cnt_d   = '0;
                    asm_d   = '0;
                    state_d = S_COLLECT;
                    if (bus.data_valid_i) begin
                        if (last_beat) begin
                            state_d    = S_IDLE;
                            wb_valid_c = 1'b1;
                            wb_data_c  = extend(merged, cur_size, cur_sgn);
                        end else begin
                            cnt_d = CNT_W'(1);
                            asm_d = merged;
                        end
                    end
                end
            end
            S_COLLECT: begin
                if (bus.data_valid_i) begin
                    if (last_beat) begin
                        state_d    = S_IDLE;
                        cnt_d      = '0;
                        asm_d      = '0;
                        wb_valid_c = 1'b1;
                        wb_data_c  = extend(merged, cur_size, cur_sgn);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        asm_d = merged;
                    end
                end
            end
        endcase
    end

    assign bus.write_back_o = wb_data_c;
    assign bus.wb_valid_o   = wb_valid_c;
    assign bus.wb_busy_o    = (state_q == S_COLLECT);

    logic [XLEN-1:0]    pc_q, pc_d, req_addr_q, addr_c;
    logic               inflight_q;
    logic               re_c, push_c, pop_c, room_c;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [QCNT_W-1:0]  count_q, count_d;
    logic [INSTR_W-1:0] instr_mem [FQ_DEPTH];
    logic [XLEN-1:0]    pc_mem    [FQ_DEPTH];

    // Room counts the in-flight response; a branch flushes so it may always issue.
    always_comb begin
        room_c   = (32'(count_q) + 32'(inflight_q)) < FQ_DEPTH;
        addr_c   = bus.branch_i ? bus.branch_pc_i : pc_q;
        re_c     = !bus.stall_fetch_i && (bus.branch_i || room_c);
        push_c   = bus.instr_rvalid_i && !bus.branch_i;
        pop_c    = (count_q != '0) && bus.fetch_ready_i && !bus.branch_i;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (re_c)              pc_d = addr_c + XLEN'(STEP_B);
        else if (bus.branch_i) pc_d = bus.branch_pc_i;
        if (bus.branch_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_c && !pop_c)      count_d = count_q + QCNT_W'(1);
            else if (!push_c && pop_c) count_d = count_q - QCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            cnt_q      <= '0;
            asm_q      <= '0;
            pc_q       <= PC_RESET;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            pc_q       <= pc_d;
            req_addr_q <= addr_c;
            inflight_q <= re_c;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage needs no reset: count_q qualifies every entry.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            instr_mem[wr_ptr_q] <= bus.instr_rdata_i;
            pc_mem[wr_ptr_q]    <= req_addr_q;
        end
    end

    assign bus.instr_mem_addr_o = addr_c;
    assign bus.instr_mem_re_o   = re_c;
    assign bus.fetch_valid_o    = (count_q != '0);
    assign bus.fetch_instr_o    = instr_mem[rd_ptr_q];
    assign bus.fetch_pc_o       = pc_mem[rd_ptr_q];
    assign bus.next_pc_o        = pc_mem[rd_ptr_q] + XLEN'(STEP_B);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_c && !pop_c && (count_q == QCNT_W'(FQ_DEPTH))));
endmodule

// File: tb/tb_wb_fetch_unit.sv
// Bench for wb_fetch_unit: directed corner cases plus random traffic against a queue-based model.
module tb_wb_fetch_unit;
    localparam int unsigned XLEN = 32, MEM_W = 16, INSTR_W = 16, FQ_DEPTH = 2;

    logic clk, rst;
    wb_fetch_unit_if #(.XLEN(XLEN), .MEM_W(MEM_W), .INSTR_W(INSTR_W)) bus ();
    wb_fetch_unit #(.XLEN(XLEN), .MEM_W(MEM_W), .INSTR_W(INSTR_W), .FQ_DEPTH(FQ_DEPTH),
                    .PC_RESET(32'h0)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp, n_bad, n_issue;

    logic        t_rst, t_ls, t_sgn, t_dv, t_cv, t_stall, t_br, t_rdy;
    logic [1:0]  t_size;
    logic [15:0] t_dr;
    logic [31:0] t_calc, t_bpc;

    logic        o_wbv, o_busy, o_re, o_fvalid;
    logic [31:0] o_wb, o_addr, o_fpc, o_npc;
    logic [15:0] o_finstr;

    typedef struct packed { logic [15:0] instr; logic [31:0] pc; } fent_t;
    bit          m_collect;
    int          m_size;
    bit          m_sgn;
    logic [15:0] m_beats[$];
    logic [31:0] m_pc;
    fent_t       m_q[$];
    bit          mem_pend;
    logic [31:0] mem_addr;
    logic [15:0] mem_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int load_bits(input int size);
        return (size == 0) ? 8 : (size == 1) ? 16 : 32;
    endfunction

    function automatic int nbeats(input int size);
        return (load_bits(size) / 16 < 1) ? 1 : load_bits(size) / 16;
    endfunction

    // Little-endian concatenation, truncate to the load width, then two's-complement fill.
    function automatic logic [31:0] load_value(input logic [15:0] bq[$], input int size, input bit sgn);
        longint unsigned raw, v, span;
        raw = 0;
        foreach (bq[i]) raw += 64'(bq[i]) << (16 * i);
        span = 64'd1 << load_bits(size);
        v = raw % span;
        if (sgn && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    task automatic defaults();
        t_rst = 0; t_ls = 0; t_size = 0; t_sgn = 0; t_dr = 0; t_dv = 0;
        t_calc = 0; t_cv = 0; t_stall = 0; t_br = 0; t_bpc = 0; t_rdy = 1;
    endtask

    task automatic model_reset();
        m_collect = 0; m_size = 0; m_sgn = 0; m_beats.delete();
        m_pc = 32'h0; m_q.delete(); mem_pend = 0; mem_addr = 0; mem_data = 0;
    endtask

    task automatic drive();
        rst                  = t_rst;
        bus.load_start_i     = t_ls;
        bus.load_size_i      = t_size;
        bus.load_signed_i    = t_sgn;
        bus.data_read_i      = t_dr;
        bus.data_valid_i     = t_dv;
        bus.data_calc_i      = t_calc;
        bus.calc_valid_i     = t_cv;
        bus.stall_fetch_i    = t_stall;
        bus.branch_i         = t_br;
        bus.branch_pc_i      = t_bpc;
        bus.fetch_ready_i    = t_rdy;
        bus.instr_rvalid_i   = mem_pend;
        bus.instr_rdata_i    = mem_data;
    endtask

    task automatic model_wb();
        bit          exp_v, exp_busy;
        logic [31:0] exp_d;
        exp_v = 0; exp_d = 0; exp_busy = m_collect;
        if (!m_collect) begin
            if (t_cv) begin exp_v = 1; exp_d = t_calc; end
            if (t_ls) begin
                m_size = int'(t_size); m_sgn = t_sgn; m_beats.delete(); m_collect = 1;
                if (t_dv) m_beats.push_back(t_dr);
            end
        end else if (t_dv) begin
            m_beats.push_back(t_dr);
        end
        if (m_collect && m_beats.size() == nbeats(m_size)) begin
            exp_v = 1; exp_d = load_value(m_beats, m_size, m_sgn); m_collect = 0;
        end
        check_eq("wb_busy", 32'(o_busy), 32'(exp_busy));
        check_eq("wb_valid", 32'(o_wbv), 32'(exp_v));
        if (exp_v) check_eq("write_back", o_wb, exp_d);
    endtask

    task automatic model_fetch();
        bit          exp_re;
        logic [31:0] exp_addr;
        fent_t       e;
        exp_re   = !t_stall && (t_br || (m_q.size() + int'(mem_pend)) < int'(FQ_DEPTH));
        exp_addr = t_br ? t_bpc : m_pc;
        check_eq("instr_re", 32'(o_re), 32'(exp_re));
        if (exp_re) check_eq("instr_addr", o_addr, exp_addr);
        check_eq("fetch_valid", 32'(o_fvalid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_eq("fetch_instr", 32'(o_finstr), 32'(m_q[0].instr));
            check_eq("fetch_pc", o_fpc, m_q[0].pc);
            check_eq("next_pc", o_npc, m_q[0].pc + 32'd2);
        end
        if (t_br) m_q.delete();
        else begin
            if (m_q.size() != 0 && t_rdy) void'(m_q.pop_front());
            if (mem_pend) begin e.instr = mem_data; e.pc = mem_addr; m_q.push_back(e); end
        end
        if (exp_re)    m_pc = exp_addr + 32'd2;
        else if (t_br) m_pc = t_bpc;
        mem_pend = exp_re; mem_addr = exp_addr; mem_data = 16'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        o_wbv = bus.wb_valid_o; o_busy = bus.wb_busy_o; o_wb = bus.write_back_o;
        o_re = bus.instr_mem_re_o; o_addr = bus.instr_mem_addr_o; o_fvalid = bus.fetch_valid_o;
        o_finstr = bus.fetch_instr_o; o_fpc = bus.fetch_pc_o; o_npc = bus.next_pc_o;
        if (t_rst) model_reset();
        else begin
            if (o_re) n_issue++;
            model_wb();
            model_fetch();
        end
    endtask

    task automatic do_reset();
        defaults(); t_rst = 1; step(); step(); t_rst = 0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_issue = 0;
        model_reset(); defaults(); t_rst = 1; drive();
        do_reset();

        // Reset state and sequential fetch with decode always ready
        step();
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_wb_valid", 32'(o_wbv), 32'd0);
        check_eq("rst_write_back", o_wb, 32'd0);
        check_eq("rst_fetch_valid", 32'(o_fvalid), 32'd0);
        check_eq("seq_re0", 32'(o_re), 32'd1);
        check_eq("seq_addr0", o_addr, 32'h0);
        step(); check_eq("seq_addr1", o_addr, 32'h2);
        step(); check_eq("seq_head_pc", o_fpc, 32'h0); check_eq("seq_next_pc", o_npc, 32'h2);
        step(); check_eq("seq_addr2", o_addr, 32'h4);

        // Half signed single beat
        defaults(); t_ls = 1; t_size = 1; t_sgn = 1; t_dv = 1; t_dr = 16'hBEEF; step();
        check_eq("half_valid", 32'(o_wbv), 32'd1);
        check_eq("half_value", o_wb, 32'hFFFF_BEEF);
        check_eq("half_busy", 32'(o_busy), 32'd0);
        defaults(); step(); check_eq("half_valid_gone", 32'(o_wbv), 32'd0);

        // Word with a two-cycle gap; ALU requests in the gap must be ignored
        defaults(); t_ls = 1; t_size = 2; t_dv = 1; t_dr = 16'h5678; step();
        check_eq("word_busy_start", 32'(o_busy), 32'd0);
        defaults(); t_cv = 1; t_calc = 32'hDEAD_BEEF; step();
        check_eq("word_gap_busy", 32'(o_busy), 32'd1);
        check_eq("word_gap_calc_ignored", 32'(o_wbv), 32'd0);
        step();
        defaults(); t_dv = 1; t_dr = 16'h1234; step();
        check_eq("word_value", o_wb, 32'h1234_5678);
        check_eq("word_end_busy", 32'(o_busy), 32'd1);
        defaults(); step(); check_eq("word_after_busy", 32'(o_busy), 32'd0);

        // Byte loads: only the low byte of the beat matters
        defaults(); t_ls = 1; t_size = 0; t_dv = 1; t_dr = 16'h0080; step();
        check_eq("byte_unsigned", o_wb, 32'h0000_0080);
        t_sgn = 1; t_dr = 16'h1280; step();
        check_eq("byte_signed", o_wb, 32'hFFFF_FF80);

        // Reset mid-load discards the partial word
        defaults(); t_ls = 1; t_size = 2; t_dv = 1; t_dr = 16'hAAAA; step();
        defaults(); t_rst = 1; step(); t_rst = 0; step();
        check_eq("rst_mid_busy", 32'(o_busy), 32'd0);
        check_eq("rst_mid_valid", 32'(o_wbv), 32'd0);
        t_ls = 1; t_size = 3; t_dv = 1; t_dr = 16'h4321; step();
        defaults(); t_dv = 1; t_dr = 16'h8765; step();
        check_eq("rst_mid_next_load", o_wb, 32'h8765_4321);

        // Decode stalled: queue fills after exactly FQ_DEPTH requests
        do_reset(); t_rdy = 0; n_issue = 0;
        repeat (6) step();
        check_eq("full_issues", 32'(n_issue), 32'd2);
        check_eq("full_re", 32'(o_re), 32'd0);
        check_eq("full_valid", 32'(o_fvalid), 32'd1);
        check_eq("full_head_pc", o_fpc, 32'h0);

        // Branch with a response in flight
        do_reset(); step();
        t_br = 1; t_bpc = 32'h100; step();
        check_eq("br_re", 32'(o_re), 32'd1);
        check_eq("br_addr", o_addr, 32'h100);
        t_br = 0; step(); check_eq("br_flushed", 32'(o_fvalid), 32'd0);
        step(); check_eq("br_head_pc", o_fpc, 32'h100);

        // PC wrap-around at the top of the address space
        t_br = 1; t_bpc = 32'hFFFF_FFFE; step();
        t_br = 0; step(); check_eq("wrap_addr", o_addr, 32'h0);
        step();
        check_eq("wrap_head_pc", o_fpc, 32'hFFFF_FFFE);
        check_eq("wrap_next_pc", o_npc, 32'h0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            defaults();
            t_rst = ($urandom_range(0, 399) == 0);
            if (!m_collect) begin
                t_ls = ($urandom_range(0, 3) == 0);
                t_dv = t_ls && ($urandom_range(0, 1) == 1);
                t_cv = !t_ls && ($urandom_range(0, 1) == 1);
            end else begin
                t_dv = ($urandom_range(0, 2) != 0);
                t_cv = ($urandom_range(0, 1) == 1);
            end
            t_size  = 2'($urandom_range(0, 3));
            t_sgn   = 1'($urandom_range(0, 1));
            t_dr    = 16'($urandom);
            t_calc  = $urandom;
            t_stall = ($urandom_range(0, 5) == 0);
            t_br    = ($urandom_range(0, 11) == 0);
            t_bpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFE);
            t_rdy   = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
